dac8551_rx: RTL and testbench

- SPI slave that receives DAC8551-format 24-bit write frames (SYNC_n, SCLK, MOSI) and presents each completed word on a parallel bus with a one-cycle valid strobe.
- Used as an on-FPGA loopback monitor and DAC model: it checks the DAC driver output in hardware and in simulation, and taps an external DAC bus.
- Oversamples the SPI pins on the system clock. It does not use SCLK as a clock.

---
 rtl/dac8551_rx.sv | 140 ++++++++++++++
 tb/tb_dac8551_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dac8551_rx.sv
// DAC8551 24-bit SPI write-frame receiver, oversampled on clk (SCLK is never used as a clock).
// Define DAC8551_RX_SYNC_EN to put a 2-flop synchronizer on the pins; otherwise a single register stage is used.
module dac8551_rx #(
   parameter int ABORT_CNT_BITS = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_sclk,
   input  logic                      i_mosi,
   input  logic                      i_sync_n,
   output logic                      o_valid,
   output logic [23:0]               o_data,
   output logic [1:0]                o_pd,
   output logic [15:0]               o_value,
   output logic                      o_rsvd_err,
   output logic                      o_abort,
   output logic [ABORT_CNT_BITS-1:0] o_abort_cnt,
   output logic                      o_busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;

   // Pin stage is deliberately not reset, so it tracks the pins during reset and
   // a SYNC_n held low across reset release is not mistaken for a fresh fall.
   logic [2:0] pin_q;  // {sync_n, mosi, sclk}
`ifdef DAC8551_RX_SYNC_EN
   logic [2:0] meta_q;
   always_ff @(posedge clk) begin
      meta_q <= {i_sync_n, i_mosi, i_sclk};
      pin_q  <= meta_q;
   end
`else
   always_ff @(posedge clk) begin
      pin_q <= {i_sync_n, i_mosi, i_sclk};
   end
`endif

   logic sclk_c, mosi_c, sync_c;
   assign sclk_c = pin_q[0];
   assign mosi_c = pin_q[1];
   assign sync_c = pin_q[2];

   logic                      sclk_p_q, sync_p_q, arm_q;
   state_e                    state_q, state_d;
   logic [4:0]                cnt_q, cnt_d;
   logic [23:0]               shift_q, shift_d;
   logic [23:0]               data_q, data_d;
   logic                      rsvd_q, rsvd_d;
   logic                      valid_q, valid_d;
   logic                      abort_q, abort_d;
   logic [ABORT_CNT_BITS-1:0] acnt_q, acnt_d;

   logic        sclk_fall, sync_fall, sync_rise;
   logic [23:0] word;

   assign sclk_fall = sclk_p_q & ~sclk_c;
   // arm_q requires SYNC_n to have been seen high since reset before a fall counts
   assign sync_fall = arm_q & sync_p_q & ~sync_c;
   assign sync_rise = ~sync_p_q & sync_c;
   assign word      = {shift_q[22:0], mosi_c};

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_p_q <= 1'b0;
         sync_p_q <= 1'b1;
         arm_q    <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         rsvd_q   <= 1'b0;
         valid_q  <= 1'b0;
         abort_q  <= 1'b0;
         acnt_q   <= '0;
      end else begin
         sclk_p_q <= sclk_c;
         sync_p_q <= sync_c;
         arm_q    <= arm_q | sync_c;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         rsvd_q   <= rsvd_d;
         valid_q  <= valid_d;
         abort_q  <= abort_d;
         acnt_q   <= acnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      rsvd_d  = rsvd_q;
      valid_d = 1'b0;
      abort_d = 1'b0;
      acnt_d  = acnt_q;
      case (state_q)
         IDLE: begin
            if (sync_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         SHIFT: begin
            // SYNC rise takes priority over a coincident SCLK fall
            if (sync_rise) begin
               abort_d = 1'b1;
               if (acnt_q != '1) acnt_d = acnt_q + 1'b1;
               state_d = IDLE;
            end else if (sclk_fall && !sync_c) begin
               shift_d = word;
               cnt_d   = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  data_d  = word;
                  rsvd_d  = |word[23:18];
                  valid_d = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (sync_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_valid     = valid_q;
   assign o_data      = data_q;
   assign o_pd        = data_q[17:16];
   assign o_value     = data_q[15:0];
   assign o_rsvd_err  = rsvd_q;
   assign o_abort     = abort_q;
   assign o_abort_cnt = acnt_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dac8551_rx.sv
// Directed bench for dac8551_rx: frames, aborts, saturation, reserved bits, reset corner cases.
module tb_dac8551_rx;
   localparam int HALF = 10;
`ifdef DAC8551_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_sclk = 1'b0, i_mosi = 1'b0, i_sync_n = 1'b1;
   logic        o_valid, o_rsvd_err, o_abort, o_busy;
   logic [23:0] o_data;
   logic [1:0]  o_pd;
   logic [15:0] o_value;
   logic [7:0]  o_abort_cnt;

   int n_chk = 0, n_err = 0, vcnt = 0, acnt = 0;
   int v0, a0;

   dac8551_rx #(.ABORT_CNT_BITS(8)) dut (
      .clk(clk), .rst(rst), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_sync_n(i_sync_n),
      .o_valid(o_valid), .o_data(o_data), .o_pd(o_pd), .o_value(o_value),
      .o_rsvd_err(o_rsvd_err), .o_abort(o_abort), .o_abort_cnt(o_abort_cnt), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (o_valid) vcnt++;
      if (o_abort) acnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n bits MSB first; returns right after driving the last falling edge
   task automatic send(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         i_sclk = 1'b1;
         i_mosi = w[23-i];
         tick(HALF);
         i_sclk = 1'b0;
         if (i != n-1) tick(HALF);
      end
   endtask

   task automatic frame(input logic [23:0] w, input int extra);
      i_sync_n = 1'b0;
      tick(4);
      send(w, 24);
      tick(HALF);
      for (int i = 0; i < extra; i++) begin
         i_sclk = 1'b1;
         i_mosi = 1'b1;
         tick(HALF);
         i_sclk = 1'b0;
         tick(HALF);
      end
      i_sync_n = 1'b1;
      tick(4);
   endtask

   task automatic abort_after(input int n);
      i_sync_n = 1'b0;
      tick(4);
      send(24'hFFFFFF, n);
      tick(HALF);
      i_sync_n = 1'b1;
      tick(4);
   endtask

   initial begin
      tick(5);
      rst = 1'b0;
      tick(2);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_rsvd", o_rsvd_err, 0);
      chk("rst_abort", o_abort, 0);
      chk("rst_acnt", o_abort_cnt, 0);
      chk("rst_busy", o_busy, 0);

      // basic frame with latency check
      i_sync_n = 1'b0;
      tick(4);
      send(24'h00ABCD, 24);
      tick(LAT-1);
      chk("lat_early", o_valid, 0);
      tick(1);
      chk("lat_hit", o_valid, 1);
      chk("f1_data", o_data, 32'h00ABCD);
      tick(1);
      chk("pulse_len", o_valid, 0);
      tick(HALF);
      i_sync_n = 1'b1;
      tick(4);
      chk("f1_vcnt", vcnt, 1);
      chk("f1_pd", o_pd, 0);
      chk("f1_value", o_value, 32'hABCD);
      chk("f1_rsvd", o_rsvd_err, 0);
      chk("f1_idle", o_busy, 0);

      // abort after 10 edges
      v0 = vcnt;
      i_sync_n = 1'b0;
      tick(4);
      send(24'h5A5A5A, 10);
      tick(HALF);
      chk("ab_busy", o_busy, 1);
      i_sync_n = 1'b1;
      tick(4);
      chk("ab_pulses", acnt, 1);
      chk("ab_cnt", o_abort_cnt, 1);
      chk("ab_novalid", vcnt, v0);
      chk("ab_hold", o_data, 32'h00ABCD);
      chk("ab_idle", o_busy, 0);

      repeat (300) abort_after(1);
      chk("sat_cnt", o_abort_cnt, 255);
      chk("sat_pulses", acnt, 301);

      // 23 edges then SYNC rise still aborts
      a0 = acnt;
      abort_after(23);
      chk("a23_pulse", acnt, a0 + 1);
      chk("a23_novalid", vcnt, v0);

      // reserved bits set, extra edges after the 24th
      a0 = acnt;
      frame(24'hFC1234, 6);
      chk("rs_vcnt", vcnt, v0 + 1);
      chk("rs_data", o_data, 32'hFC1234);
      chk("rs_err", o_rsvd_err, 1);
      chk("rs_pd", o_pd, 0);
      chk("rs_value", o_value, 32'h1234);
      chk("rs_noabort", acnt, a0);

      // back-to-back frames
      frame(24'h010001, 0);
      chk("bb1_pd", o_pd, 1);
      chk("bb1_value", o_value, 32'h0001);
      chk("bb1_rsvd", o_rsvd_err, 0);
      frame(24'h03FFFF, 0);
      chk("bb2_pd", o_pd, 3);
      chk("bb2_value", o_value, 32'hFFFF);
      chk("bb_vcnt", vcnt, v0 + 3);

      // SYNC_n low across reset release
      rst = 1'b1;
      i_sync_n = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(4);
      v0 = vcnt;
      send(24'h002222, 24);
      tick(HALF + 4);
      chk("sl_novalid", vcnt, v0);
      chk("sl_data", o_data, 0);
      chk("sl_busy", o_busy, 0);
      i_sync_n = 1'b1;
      tick(4);
      frame(24'h001111, 0);
      chk("sl_vcnt", vcnt, v0 + 1);
      chk("sl_frame", o_data, 32'h001111);

      // reset mid-frame
      a0 = acnt;
      i_sync_n = 1'b0;
      tick(4);
      send(24'h00FFFF, 12);
      tick(HALF);
      rst = 1'b1;
      tick(3);
      i_sync_n = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
      chk("mr_noabort", acnt, a0);
      chk("mr_novalid", vcnt, v0 + 1);
      chk("mr_busy", o_busy, 0);
      frame(24'h005555, 0);
      chk("mr_vcnt", vcnt, v0 + 2);
      chk("mr_data", o_data, 32'h005555);
      chk("mr_noabort2", acnt, a0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
